// File: rtl/acia_pkg.sv
// Shared ACIA definitions: FIFO sizing defaults and status-register bit positions.
package acia_pkg;

  localparam int unsigned ACIA_DEPTH_LOG2 = 4;
  localparam int unsigned ACIA_IRQ_LEVEL  = 8;

  // Status register bit positions (6551-style layout)
  localparam int unsigned STAT_FE_BIT       = 1;
  localparam int unsigned STAT_OVR_BIT      = 2;
  localparam int unsigned STAT_RD_VALID_BIT = 3;
  localparam int unsigned STAT_IRQ_BIT      = 7;

endpackage

// File: rtl/acia_rx_fifo_if.sv
// Receiver/bus-side signal bundle for the ACIA receive FIFO.
interface acia_rx_fifo_if #(
  parameter int unsigned DEPTH_LOG2 = acia_pkg::ACIA_DEPTH_LOG2
);
  logic [7:0]          rx_dat;
  logic                rx_stb;
  logic                rx_err;
  logic                rd_stb;
  logic                flag_clr;
  logic [7:0]          rd_dat;
  logic                rd_fe;
  logic                rd_valid;
  logic [DEPTH_LOG2:0] count;
  logic                ovr;
  logic                fe;
  logic                irq;

  modport master (
    output rx_dat, rx_stb, rx_err, rd_stb, flag_clr,
    input  rd_dat, rd_fe, rd_valid, count, ovr, fe, irq
  );

  modport slave (
    input  rx_dat, rx_stb, rx_err, rd_stb, flag_clr,
    output rd_dat, rd_fe, rd_valid, count, ovr, fe, irq
  );
endinterface

// File: rtl/acia_fifo_mem.sv
// Dual-port storage array: synchronous write, asynchronous (show-ahead) read.
module acia_fifo_mem #(
  parameter int unsigned Width = 8,
  parameter int unsigned AddrW = 4
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AddrW-1:0] waddr,
  input  logic [Width-1:0] wdata,
  input  logic [AddrW-1:0] raddr,
  output logic [Width-1:0] rdata
);

  logic [Width-1:0] mem [2**AddrW];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/acia_rx_fifo.sv
// ACIA receive FIFO: pointers, occupancy, sticky flags and level interrupt.
// Define ACIA_RX_FIFO_ERRPUSH_EN to also queue framing-error bytes tagged with rd_fe.
module acia_rx_fifo
  import acia_pkg::*;
#(
  parameter int unsigned DEPTH_LOG2 = ACIA_DEPTH_LOG2,
  parameter int unsigned IRQ_LEVEL  = ACIA_IRQ_LEVEL
) (
  input logic           clk,
  input logic           reset,
  acia_rx_fifo_if.slave bus
);

`ifdef ACIA_RX_FIFO_ERRPUSH_EN
  localparam int unsigned EntryW = 9;
`else
  localparam int unsigned EntryW = 8;
`endif

  localparam logic [DEPTH_LOG2:0]   DepthCnt = {1'b1, {DEPTH_LOG2{1'b0}}};
  localparam logic [DEPTH_LOG2:0]   IrqLvl   = IRQ_LEVEL[DEPTH_LOG2:0];
  localparam logic [DEPTH_LOG2:0]   CntOne   = {{DEPTH_LOG2{1'b0}}, 1'b1};
  localparam logic [DEPTH_LOG2-1:0] PtrOne   = {{(DEPTH_LOG2-1){1'b0}}, 1'b1};

  logic [DEPTH_LOG2-1:0] wr_ptr, wr_ptr_nxt;
  logic [DEPTH_LOG2-1:0] rd_ptr, rd_ptr_nxt;
  logic [DEPTH_LOG2:0]   cnt, cnt_nxt;
  logic                  ovr_r, ovr_nxt;
  logic                  fe_r, fe_nxt;
  logic                  err_d;

  logic              err_evt;
  logic              push_req;
  logic              push_ok;
  logic              pop;
  logic              full;
  logic              empty;
  logic [EntryW-1:0] wr_entry;
  logic [EntryW-1:0] rd_entry;

  // One event per rising edge of the framing-error level
  assign err_evt = bus.rx_err & ~err_d;

`ifdef ACIA_RX_FIFO_ERRPUSH_EN
  assign push_req   = bus.rx_stb | err_evt;
  assign wr_entry   = {~bus.rx_stb, bus.rx_dat};
  assign bus.rd_fe  = rd_entry[8];
  assign bus.rd_dat = rd_entry[7:0];
`else
  assign push_req   = bus.rx_stb;
  assign wr_entry   = bus.rx_dat;
  assign bus.rd_fe  = 1'b0;
  assign bus.rd_dat = rd_entry;
`endif

  assign full  = (cnt == DepthCnt);
  assign empty = (cnt == '0);
  assign pop   = bus.rd_stb & ~empty;
  // A full FIFO still accepts a push when the same cycle frees a slot
  assign push_ok = push_req & (~full | pop);

  always_comb begin
    wr_ptr_nxt = wr_ptr;
    rd_ptr_nxt = rd_ptr;
    cnt_nxt    = cnt;
    if (push_ok) wr_ptr_nxt = wr_ptr + PtrOne;
    if (pop)     rd_ptr_nxt = rd_ptr + PtrOne;
    if (push_ok && !pop)      cnt_nxt = cnt + CntOne;
    else if (pop && !push_ok) cnt_nxt = cnt - CntOne;
    ovr_nxt = (push_req & ~push_ok) | (ovr_r & ~bus.flag_clr);
    fe_nxt  = err_evt | (fe_r & ~bus.flag_clr);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
      ovr_r  <= 1'b0;
      fe_r   <= 1'b0;
      err_d  <= 1'b0;
    end else begin
      wr_ptr <= wr_ptr_nxt;
      rd_ptr <= rd_ptr_nxt;
      cnt    <= cnt_nxt;
      ovr_r  <= ovr_nxt;
      fe_r   <= fe_nxt;
      err_d  <= bus.rx_err;
    end
  end

  acia_fifo_mem #(
    .Width (EntryW),
    .AddrW (DEPTH_LOG2)
  ) u_mem (
    .clk   (clk),
    .we    (push_ok),
    .waddr (wr_ptr),
    .wdata (wr_entry),
    .raddr (rd_ptr),
    .rdata (rd_entry)
  );

  assign bus.count    = cnt;
  assign bus.rd_valid = ~empty;
  assign bus.ovr      = ovr_r;
  assign bus.fe       = fe_r;
  assign bus.irq      = (cnt >= IrqLvl) | ovr_r;

endmodule

// File: tb/tb_acia_rx_fifo.sv
// Directed self-checking bench for acia_rx_fifo (DEPTH_LOG2=4, IRQ_LEVEL=8).
module tb_acia_rx_fifo;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   tests = 0;
  int   fails = 0;

  always #5 clk = ~clk;

  acia_rx_fifo_if #(.DEPTH_LOG2(4)) bus ();

  acia_rx_fifo #(
    .DEPTH_LOG2 (4),
    .IRQ_LEVEL  (8)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [7:0] b);
    bus.rx_dat = b;
    bus.rx_stb = 1'b1;
    tick();
    bus.rx_stb = 1'b0;
  endtask

  task automatic pop();
    bus.rd_stb = 1'b1;
    tick();
    bus.rd_stb = 1'b0;
  endtask

  task automatic test_reset();
    bus.rx_dat = 8'h00; bus.rx_stb = 1'b0; bus.rx_err = 1'b0;
    bus.rd_stb = 1'b0;  bus.flag_clr = 1'b0;
    reset = 1'b1;
    #12;
    tests++;
    if (bus.count !== 5'd0 || bus.rd_valid !== 1'b0 || bus.ovr !== 1'b0 ||
        bus.fe !== 1'b0 || bus.irq !== 1'b0) begin
      fails++;
      $display("FAIL reset_state: count=%0d valid=%b ovr=%b fe=%b irq=%b, want 0 0 0 0 0",
               bus.count, bus.rd_valid, bus.ovr, bus.fe, bus.irq);
    end
    reset = 1'b0;
    tick();
  endtask

  task automatic test_basic();
    push(8'h41); push(8'h42); push(8'h43);
    tests++;
    if (bus.count !== 5'd3 || bus.rd_dat !== 8'h41 || bus.rd_fe !== 1'b0) begin
      fails++;
      $display("FAIL basic_push3: count=%0d dat=%h fe_tag=%b, want 3 41 0",
               bus.count, bus.rd_dat, bus.rd_fe);
    end
    pop();
    tests++;
    if (bus.rd_dat !== 8'h42) begin
      fails++; $display("FAIL basic_pop1: dat=%h, want 42", bus.rd_dat);
    end
    pop();
    tests++;
    if (bus.rd_dat !== 8'h43 || bus.count !== 5'd1) begin
      fails++;
      $display("FAIL basic_pop2: dat=%h count=%0d, want 43 1", bus.rd_dat, bus.count);
    end
    pop();
    tests++;
    if (bus.rd_valid !== 1'b0 || bus.count !== 5'd0) begin
      fails++;
      $display("FAIL basic_empty: valid=%b count=%0d, want 0 0", bus.rd_valid, bus.count);
    end
    // Pop while empty: no state change
    pop();
    tests++;
    if (bus.rd_valid !== 1'b0 || bus.count !== 5'd0) begin
      fails++;
      $display("FAIL pop_empty: valid=%b count=%0d, want 0 0", bus.rd_valid, bus.count);
    end
  endtask

  task automatic test_overrun();
    for (int i = 0; i < 16; i++) push(8'(i));
    tests++;
    if (bus.count !== 5'd16 || bus.ovr !== 1'b0) begin
      fails++;
      $display("FAIL ovr_fill: count=%0d ovr=%b, want 16 0", bus.count, bus.ovr);
    end
    push(8'hAA);
    tests++;
    if (bus.count !== 5'd16 || bus.ovr !== 1'b1 || bus.irq !== 1'b1) begin
      fails++;
      $display("FAIL ovr_drop: count=%0d ovr=%b irq=%b, want 16 1 1",
               bus.count, bus.ovr, bus.irq);
    end
    for (int i = 0; i < 16; i++) begin
      tests++;
      if (bus.rd_valid !== 1'b1 || bus.rd_dat !== 8'(i)) begin
        fails++;
        $display("FAIL ovr_drain[%0d]: valid=%b dat=%h, want 1 %h",
                 i, bus.rd_valid, bus.rd_dat, 8'(i));
      end
      pop();
    end
    tests++;
    if (bus.rd_valid !== 1'b0 || bus.irq !== 1'b1) begin
      fails++;
      $display("FAIL ovr_after_drain: valid=%b irq=%b, want 0 1", bus.rd_valid, bus.irq);
    end
    bus.flag_clr = 1'b1;
    tick();
    bus.flag_clr = 1'b0;
    tests++;
    if (bus.ovr !== 1'b0 || bus.irq !== 1'b0) begin
      fails++;
      $display("FAIL ovr_clear: ovr=%b irq=%b, want 0 0", bus.ovr, bus.irq);
    end
  endtask

  task automatic test_full_push_pop();
    for (int i = 0; i < 16; i++) push(8'h10 + 8'(i));
    bus.rx_dat = 8'h55;
    bus.rx_stb = 1'b1;
    bus.rd_stb = 1'b1;
    tick();
    bus.rx_stb = 1'b0;
    bus.rd_stb = 1'b0;
    tests++;
    if (bus.count !== 5'd16 || bus.ovr !== 1'b0 || bus.rd_dat !== 8'h11) begin
      fails++;
      $display("FAIL full_pushpop: count=%0d ovr=%b dat=%h, want 16 0 11",
               bus.count, bus.ovr, bus.rd_dat);
    end
    for (int i = 1; i < 16; i++) pop();
    tests++;
    if (bus.count !== 5'd1 || bus.rd_dat !== 8'h55) begin
      fails++;
      $display("FAIL full_last: count=%0d dat=%h, want 1 55", bus.count, bus.rd_dat);
    end
    pop();
  endtask

  task automatic test_irq();
    for (int i = 0; i < 7; i++) push(8'h60 + 8'(i));
    tests++;
    if (bus.irq !== 1'b0 || bus.count !== 5'd7) begin
      fails++;
      $display("FAIL irq_below: irq=%b count=%0d, want 0 7", bus.irq, bus.count);
    end
    push(8'h67);
    tests++;
    if (bus.irq !== 1'b1) begin
      fails++; $display("FAIL irq_level: irq=%b, want 1", bus.irq);
    end
    pop();
    tests++;
    if (bus.irq !== 1'b0 || bus.rd_dat !== 8'h61) begin
      fails++;
      $display("FAIL irq_drop: irq=%b dat=%h, want 0 61", bus.irq, bus.rd_dat);
    end
    for (int i = 0; i < 7; i++) pop();
  endtask

  task automatic test_frame_err();
    bus.rx_dat = 8'h7E;
    bus.rx_err = 1'b1;
    tick(); tick(); tick();
    bus.rx_err = 1'b0;
    tick();
    tests++;
    if (bus.fe !== 1'b1) begin
      fails++; $display("FAIL fe_set: fe=%b, want 1", bus.fe);
    end
`ifdef ACIA_RX_FIFO_ERRPUSH_EN
    tests++;
    if (bus.count !== 5'd1 || bus.rd_fe !== 1'b1 || bus.rd_dat !== 8'h7E) begin
      fails++;
      $display("FAIL fe_push: count=%0d tag=%b dat=%h, want 1 1 7e",
               bus.count, bus.rd_fe, bus.rd_dat);
    end
    pop();
`else
    tests++;
    if (bus.count !== 5'd0) begin
      fails++; $display("FAIL fe_nopush: count=%0d, want 0", bus.count);
    end
`endif
    bus.flag_clr = 1'b1;
    tick();
    tests++;
    if (bus.fe !== 1'b0) begin
      fails++; $display("FAIL fe_clear: fe=%b, want 0", bus.fe);
    end
    bus.rx_err = 1'b1;
    tick();
    bus.rx_err = 1'b0;
    bus.flag_clr = 1'b0;
    tests++;
    if (bus.fe !== 1'b1) begin
      fails++; $display("FAIL fe_set_wins: fe=%b, want 1", bus.fe);
    end
    while (bus.rd_valid === 1'b1) pop();
    bus.flag_clr = 1'b1;
    tick();
    bus.flag_clr = 1'b0;
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 17; i++) push(8'h80 + 8'(i));
    for (int i = 0; i < 11; i++) pop();
    tests++;
    if (bus.count !== 5'd5 || bus.ovr !== 1'b1) begin
      fails++;
      $display("FAIL mid_setup: count=%0d ovr=%b, want 5 1", bus.count, bus.ovr);
    end
    #2;
    reset = 1'b1;
    #1;
    tests++;
    if (bus.count !== 5'd0 || bus.rd_valid !== 1'b0 || bus.ovr !== 1'b0 ||
        bus.irq !== 1'b0) begin
      fails++;
      $display("FAIL mid_reset: count=%0d valid=%b ovr=%b irq=%b, want 0 0 0 0",
               bus.count, bus.rd_valid, bus.ovr, bus.irq);
    end
    #1;
    reset = 1'b0;
    tick();
    push(8'h99);
    tests++;
    if (bus.count !== 5'd1 || bus.rd_dat !== 8'h99) begin
      fails++;
      $display("FAIL mid_after: count=%0d dat=%h, want 1 99", bus.count, bus.rd_dat);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_overrun();
    test_full_push_pop();
    test_irq();
    test_frame_err();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/acia_rx_fifo.md
# acia_rx_fifo

Receive buffer between the serial receiver and the 6502 bus interface. Accepts bytes and framing-error events from the receiver, stores them in a circular FIFO, and presents the oldest entry to the ACIA register logic as a show-ahead read port. Reports occupancy, sticky overrun and framing-error flags, and a level interrupt so the CPU can service reception in bursts instead of per byte.

## Interface
Parameters:
- `DEPTH_LOG2`, default 4: FIFO holds 2^DEPTH_LOG2 entries (16).
- `IRQ_LEVEL`, default 8: `irq` asserts when `count` >= this value; legal range 1..2^DEPTH_LOG2.

Ports:
- `clk`  in  1  system clock.
- `reset`  in  1  asynchronous, active-high reset.
- `rx_dat`  in  8  byte from receiver; valid on `rx_stb` and on `rx_err` rising edge.
- `rx_stb`  in  1  one-cycle strobe: good byte available.
- `rx_err`  in  1  receiver framing-error level; rises when a bad frame completes.
- `rd_stb`  in  1  one-cycle pop request from the bus interface.
- `flag_clr`  in  1  one-cycle clear of `ovr` and `fe`.
- `rd_dat`  out  8  head-entry data.
- `rd_fe`  out  1  head-entry framing-error tag.
- `rd_valid`  out  1  FIFO not empty.
- `count`  out  DEPTH_LOG2+1  entries stored, 0..2^DEPTH_LOG2.
- `ovr`  out  1  sticky: a push was dropped because the FIFO was full.
- `fe`  out  1  sticky: a framing error was reported.
- `irq`  out  1  `count >= IRQ_LEVEL` OR `ovr`.

## Operation
- Storage: 2^DEPTH_LOG2 entries of 9 bits {tag, data}; write pointer, read pointer (DEPTH_LOG2 bits, wrap naturally), separate `count` register.
- Error detect: `rx_err` registered into `err_d`; error event = `rx_err & ~err_d`. Consecutive bad frames with no good byte between give one event only.
- Push request: `rx_stb` (tag 0), or error event when the macro in Configuration is defined (tag 1). `rx_stb` and error event never coincide; if they do, `rx_stb` wins.
- Error event always sets `fe`, regardless of configuration.
- Pop: `rd_stb & rd_valid`. `rd_stb` while empty is ignored, no state change.
- Full (`count == 2^DEPTH_LOG2`) and push without pop: data dropped, `ovr` set, pointers/count unchanged.
- Full with push and pop same cycle: both performed, count unchanged, `ovr` not set.
- Empty with push and `rd_stb` same cycle: push performed, pop ignored, count becomes 1.
- Otherwise count +1 on push only, -1 on pop only, unchanged on both.
- `flag_clr`: clears `ovr` and `fe`; a set event in the same cycle wins (flag stays 1).
- Reset mid-operation: all contents discarded; storage array itself need not be reset.

## Timing
- Reset values: pointers 0, `count` 0, `rd_valid` 0, `ovr` 0, `fe` 0, `irq` 0, `err_d` 0; `rd_dat`/`rd_fe` don't-care while `rd_valid`=0.
- Push at edge N: `count`, `rd_valid` reflect it after edge N (visible cycle N+1).
- `rd_dat`/`rd_fe` are an asynchronous read of the entry at the read pointer; after a pop at edge N the next entry is presented in cycle N+1, no bubble.
- `irq`, `rd_valid` are combinational from registered `count`/`ovr` only; no input-to-output combinational path.
- Throughput: one push and one pop per cycle sustained.

## Configuration
- `ACIA_RX_FIFO_ERRPUSH_EN` defined: each error event pushes `rx_dat` with tag 1, subject to the same full/overrun rules; the CPU sees exactly where the bad byte sat in the stream.
- Not defined: error events only set `fe`; nothing pushed; `rd_fe` tied 0; tag bit removed from storage (8-bit entries).

## Structure
- Shared package `acia_pkg`: default `DEPTH_LOG2`, `IRQ_LEVEL`, ACIA status-register bit positions for `rd_valid`, `ovr`, `fe`, `irq`.
- Sub-module `acia_fifo_mem`: dual-port array, synchronous write, asynchronous read, parameterised width/depth; pointer, count and flag logic stay in `acia_rx_fifo`.

## Test plan
- After reset, push 0x41, 0x42, 0x43 via `rx_stb` -> `count`=3, `rd_dat`=0x41; three pops -> 0x42, 0x43, then `rd_valid`=0, `count`=0.
- Push 16 bytes 0x00..0x0F, then 0xAA -> `count`=16, `ovr`=1, `irq`=1; pops return 0x00..0x0F, 0xAA never appears; `flag_clr` -> `ovr`=0.
- Full FIFO, `rx_stb`=0x55 and `rd_stb` same cycle -> `count` stays 16, `ovr`=0, 0x55 is last entry read.
- Push 7 bytes -> `irq`=0; 8th -> `irq`=1 next cycle; one pop -> `irq`=0.
- `rx_err` rises with `rx_dat`=0x7E, held 3 cycles -> `fe`=1; with macro: one entry, `rd_fe`=1, `rd_dat`=0x7E; without: `count`=0. `flag_clr` coincident with new event -> `fe` stays 1.
- Assert `reset` with 5 entries and `ovr`=1 -> immediately `count`=0, `rd_valid`=0, `ovr`=0, `irq`=0; next push read back correctly.
